// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : receiver FSM state type and bit-period helper           |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  function automatic int uart_bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_fifo : synchronous first-word-fall-through FIFO               |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_receiver : 8N1 UART receiver with FWFT receive FIFO           |
// | Option   : UART_RX_PARITY_EN selects 8E1 framing and parity_err    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ  = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  input  logic                         rd_en,
  input  logic                         err_clear,
  output logic [7:0]                   rd_data,
  output logic                         rx_empty,
  output logic                         rx_full,
  output logic [$clog2(BUFFER_SIZE):0] rx_count,
  output logic                         frame_err,
  output logic                         overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                         parity_err
`endif
);

  localparam int BIT_CYCLES = uart_bit_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  // Counter starts the cycle after t0, so HALF-2 lands on t0+HALF-1
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 2);

  logic            rx_meta, rxs;
  rx_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            push, frame_set, overrun_set;
`ifdef UART_RX_PARITY_EN
  logic            parity_set;
`endif

  uart_fifo #(.WIDTH(8), .DEPTH(BUFFER_SIZE)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (shreg),
    .pop     (rd_en),
    .rd_data (rd_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  assign overrun_set = push && rx_full && !rd_en;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rxs, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state_n = PARITY;
`else
          if (bit_idx == 3'd7) state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n      = '0;
          parity_set = (rxs != ^shreg);
          state_n    = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            frame_set = 1'b1;
            state_n   = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_meta     <= rx;
      rxs         <= rx_meta;
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      frame_err   <= frame_set | (frame_err & ~err_clear);
      overrun_err <= overrun_set | (overrun_err & ~err_clear);
`ifdef UART_RX_PARITY_EN
      parity_err  <= parity_set | (parity_err & ~err_clear);
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver with an integrated receive buffer. It is the receive end of the SoC's 8N1 UART link: it samples the `rx` pin, reassembles bytes, and queues them for a bus-side reader. It sits between the board `RxD` pin and the SoC peripheral register file, and uses the same `CLOCK_FREQ`, `BAUD_RATE` and buffer-size parameters as the SoC.

## Interface
- `CLOCK_FREQ`, 100_000_000, core clock frequency in Hz.
- `BAUD_RATE`, 115200, line bit rate.
- `BUFFER_SIZE`, 16, receive FIFO depth. Must be a power of two and ≥2.
- `clk`  in  1  core clock. Single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial line input, asynchronous to `clk`; idles high.
- `rd_en`  in  1  pop request. Ignored when the FIFO is empty.
- `err_clear`  in  1  clears the sticky error flags.
- `rd_data`  out  8  FIFO head (first-word fall-through); reset value 0x00.
- `rx_empty`  out  1  FIFO empty; reset value 1.
- `rx_full`  out  1  FIFO full; reset value 0.
- `rx_count`  out  $clog2(BUFFER_SIZE)+1  occupancy; reset value 0.
- `frame_err`  out  1  sticky: stop bit was sampled low; reset value 0.
- `overrun_err`  out  1  sticky: a byte arrived while the FIFO was full; reset value 0.
- `parity_err`  out  1  sticky; present only with `UART_RX_PARITY_EN`; reset value 0.

## Operation
- `BIT_CYCLES = CLOCK_FREQ / BAUD_RATE`, truncated; 868 at the defaults. `HALF = BIT_CYCLES / 2`, which is 434.
- `rx` passes through a 2-FF synchronizer whose flops reset to 1. All logic below uses the synchronized `rxs`.
- States:
  - IDLE: `rxs == 0` → START, and the counter clears.
  - START: when the counter reaches HALF−1, sample `rxs`. If 1, treat it as a glitch and return to IDLE. If 0, go to DATA with the counter and bit index cleared.
  - DATA: sample every BIT_CYCLES, LSB first, into the shift register. After bit 7, go to STOP (or PARITY).
  - PARITY (macro only): sample after BIT_CYCLES, then go to STOP.
  - STOP: sample after BIT_CYCLES.
    - If 1: push the byte, then go to IDLE.
    - If 0: set `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs == 1`, then go to IDLE.
- Push into a full FIFO: drop the byte and set `overrun_err`. When `rd_en` is asserted in the same cycle as that push, the pop frees a slot: the push is accepted, count is unchanged, and no overrun is flagged.
- Push and pop in the same cycle on a non-empty FIFO: count is unchanged.
- Pointers wrap modulo BUFFER_SIZE.
- Error flags: set has priority over `err_clear` in the same cycle.
- `rst` asserted mid-byte: the FSM returns to IDLE and the FIFO empties. All outputs take their reset values immediately (asynchronous).

## Timing
- Let t0 be the cycle IDLE sees `rxs == 0`. This is 2–3 cycles after the pin falls.
- Start sample: t0+HALF−1.
- Data bit i sample: t0+HALF−1+(i+1)·BIT_CYCLES.
- Stop sample: t0+HALF−1+9·BIT_CYCLES (10·BIT_CYCLES with parity).
- The FIFO write is registered on the stop-sample cycle. `rx_empty` falls, and `rd_data`/`rx_count` update, on the next cycle.
- Pop: with `rd_en` at cycle t, `rd_data`, `rx_count`, `rx_empty` and `rx_full` reflect the pop at t+1.
- Error flags assert the cycle after the offending sample.
- Back-to-back frames are supported: IDLE is re-entered right after the stop sample, at mid-stop-bit.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1, with an even parity bit between bit 7 and stop.
  - A mismatch sets `parity_err`. The byte is still pushed.
  - `parity_err` is cleared by `err_clear`.
- Undefined: the frame is 8N1. There is no PARITY state and no `parity_err` port.

## Structure
- Package `uart_pkg`: holds the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK) and a `uart_bit_cycles(clk, baud)` constant function.
- Sub-module `uart_fifo`: a synchronous FWFT FIFO parameterized by WIDTH and DEPTH. It provides `full`, `empty` and `count` outputs and the push/pop-same-cycle rule above. It is reused later by the transmit path.
- The synchronizer, baud counter and FSM stay in `uart_receiver`.

## Test plan
- Defaults, send 0xA5 8N1 → `rd_data`=0xA5. `rx_empty` falls exactly one cycle after the predicted stop sample. `rx_count`=1, no errors.
- 200-cycle low pulse on `rx` → returns to IDLE at the start sample; `rx_empty` stays 1.
- Send 0x3C with the stop bit held low for 2 bit-times → `frame_err`=1, FIFO empty. Then 0x42 is received correctly. `err_clear` drops `frame_err`.
- 17 bytes 0x00..0x10 with no reads → `rx_full`=1, `rx_count`=16, `overrun_err`=1. Reads return 0x00..0x0F in order.
- FIFO full, `rd_en` pulsed in the stop-sample cycle of byte 0x77 → no overrun, count stays 16, and 0x77 is read last.
- `rst` pulsed during bit 4 of a frame → all outputs reset. The next full frame 0x81 is received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 → `parity_err`=1 and `rd_data`=0x07.
